// File: rtl/mem_stage_hs.sv
// Memory stage with a request/done handshake to variable-latency data memory,
// byte-lane steering, alignment checking, halt/dump sequencing and lt/lte flags.

module mem_lane #(
    parameter int LANE  = 0,
    parameter int OFF_W = 1
) (
    input  logic             byte_op,
    input  logic [OFF_W-1:0] off,
    input  logic [7:0]       r2_lane,
    input  logic [7:0]       r2_low,
    output logic             be,
    output logic [7:0]       wdata
);
    // A byte store drives the low byte of r2 onto every lane; only the addressed lane is enabled.
    assign be    = ~byte_op | (off == OFF_W'(LANE));
    assign wdata = byte_op ? r2_low : r2_lane;
endmodule

module mem_stage_hs #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int BYTE_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic                ex_mem_en,
    input  logic                ex_mem_wr,
    input  logic                ex_byte,
    input  logic                ex_signed,
    input  logic                ex_halt,
    input  logic [DATA_W-1:0]   ex_alu_out,
    input  logic [DATA_W-1:0]   ex_r2,
    input  logic                ex_zero,
    input  logic                ex_ofl,
    output logic                stall,
    output logic                dm_req,
    output logic                dm_wr,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W/8-1:0] dm_be,
    input  logic                dm_done,
    input  logic [DATA_W-1:0]   dm_rdata,
    output logic                wb_valid,
    output logic [DATA_W-1:0]   wb_data,
    output logic                wb_err,
    output logic                lt,
    output logic                lte,
    output logic                dump
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, BUSY, HALTED} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0]     ex_addr;
    logic [OFF_W-1:0]      ex_off;
    logic                  illegal;
    logic                  acc_alu, acc_mem, acc_err, acc_halt, acc_any;
    logic                  lt_nxt;
    logic [LANES-1:0]      lane_be;
    logic [LANES-1:0][7:0] lane_wdata;

    logic                  op_byte, op_signed;
    logic [OFF_W-1:0]      op_off;
    logic [DATA_W-1:0]     op_alu;
    logic [7:0]            rd_byte;
    logic [DATA_W-1:0]     ld_data;

    assign ex_addr = ex_alu_out[ADDR_W-1:0];
    assign ex_off  = ex_addr[OFF_W-1:0];
    assign illegal = ex_byte ? (BYTE_EN == 0) : (ex_off != '0);
    assign lt_nxt  = ex_alu_out[DATA_W-1] ^ ex_ofl;
    assign acc_any = acc_alu | acc_mem | acc_err | acc_halt;
    assign stall   = (state != IDLE);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mem_lane #(.LANE(g), .OFF_W(OFF_W)) u_lane (
            .byte_op (ex_byte),
            .off     (ex_off),
            .r2_lane (ex_r2[g*8 +: 8]),
            .r2_low  (ex_r2[7:0]),
            .be      (lane_be[g]),
            .wdata   (lane_wdata[g])
        );
    end

    // Halt outranks any memory access on the same instruction.
    always_comb begin
        state_nxt = state;
        acc_alu   = 1'b0;
        acc_mem   = 1'b0;
        acc_err   = 1'b0;
        acc_halt  = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_halt) begin
                        acc_halt  = 1'b1;
                        state_nxt = HALTED;
                    end else if (!ex_mem_en) begin
                        acc_alu = 1'b1;
                    end else if (illegal) begin
                        acc_err = 1'b1;
                    end else begin
                        acc_mem   = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY:    if (dm_done) state_nxt = IDLE;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_byte = dm_rdata[7:0];
        for (int i = 0; i < LANES; i++)
            if (op_off == OFF_W'(i)) rd_byte = dm_rdata[i*8 +: 8];
        if (op_byte) ld_data = {{(DATA_W-8){op_signed & rd_byte[7]}}, rd_byte};
        else         ld_data = dm_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dm_req    <= 1'b0;
            dm_wr     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            dm_be     <= '0;
            wb_valid  <= 1'b0;
            wb_data   <= '0;
            wb_err    <= 1'b0;
            lt        <= 1'b0;
            lte       <= 1'b0;
            dump      <= 1'b0;
            op_byte   <= 1'b0;
            op_signed <= 1'b0;
            op_off    <= '0;
            op_alu    <= '0;
        end else begin
            state    <= state_nxt;
            wb_valid <= 1'b0;
            wb_err   <= 1'b0;
            dump     <= acc_halt;
            if (acc_any) begin
                lt  <= lt_nxt;
                lte <= lt_nxt | ex_zero;
            end
            if (acc_alu) begin
                wb_valid <= 1'b1;
                wb_data  <= ex_alu_out;
            end
            if (acc_err) begin
                wb_valid <= 1'b1;
                wb_err   <= 1'b1;
                wb_data  <= '0;
            end
            if (acc_mem) begin
                dm_req    <= 1'b1;
                dm_wr     <= ex_mem_wr;
                dm_addr   <= {ex_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                dm_wdata  <= lane_wdata;
                dm_be     <= lane_be;
                op_byte   <= ex_byte;
                op_signed <= ex_signed;
                op_off    <= ex_off;
                op_alu    <= ex_alu_out;
            end
            // Request fields stay frozen until the memory signals completion.
            if (state == BUSY && dm_done) begin
                dm_req   <= 1'b0;
                wb_valid <= 1'b1;
                wb_data  <= dm_wr ? op_alu : ld_data;
            end
        end
    end
endmodule
